// File: rtl/serdes_pkg.sv
// Shared serdes types and constants.
// Used by both the receive and transmit sides.
package serdes_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_RECEIVING
  } rx_state_e;

  localparam int SERDES_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/rx_deserializer_if.sv
// Serial input, parallel output and status bundle
// for the receive deserializer.
interface rx_deserializer_if
  import serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_WIDTH_DEFAULT
);

  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             frame_error;
  logic             overrun;
  logic             overrun_clr;

  modport slave (
    input  serial_in,
    input  serial_valid,
    input  data_ready,
    input  overrun_clr,
    output data_out,
    output data_valid,
    output busy,
    output frame_error,
    output overrun
  );

  modport master (
    output serial_in,
    output serial_valid,
    output data_ready,
    output overrun_clr,
    input  data_out,
    input  data_valid,
    input  busy,
    input  frame_error,
    input  overrun
  );

endinterface

// File: rtl/rx_word_buffer.sv
// One-entry output register with valid/ready handshake
// and sticky overrun flag.
module rx_word_buffer
  import serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic xfer;
  logic drop;

  assign xfer = valid && ready;
  assign drop = load && valid && !ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load && (!valid || xfer)) begin
      data  <= word;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

  // Set wins over clear when both land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_deserializer.sv
// Serial-to-parallel receiver, LSB first, with
// mid-word gap timeout and one-entry output buffer.
module rx_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH       = SERDES_WIDTH_DEFAULT,
  parameter int GAP_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  rx_deserializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  rx_state_e        state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gap, gap_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             abort;
  logic             frame_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      gap         <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gap         <= gap_n;
      shift       <= shift_n;
      frame_error <= abort;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gap_n   = gap;
    shift_n = shift;
    word    = '0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (bus.serial_valid) begin
          shift_n    = '0;
          shift_n[0] = bus.serial_in;
          cnt_n      = CW'(1);
          gap_n      = '0;
          state_n    = RX_RECEIVING;
        end
      end
      RX_RECEIVING: begin
        if (bus.serial_valid) begin
          shift_n[cnt] = bus.serial_in;
          gap_n        = '0;
          // Last bit hands the word straight to the buffer.
          if (cnt == LAST_BIT) begin
            done    = 1'b1;
            word    = shift_n;
            shift_n = '0;
            cnt_n   = '0;
            state_n = RX_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else if (gap == GAP_LAST) begin
          abort   = 1'b1;
          shift_n = '0;
          cnt_n   = '0;
          gap_n   = '0;
          state_n = RX_IDLE;
        end else begin
          gap_n = gap + GW'(1);
        end
      end
    endcase
  end

  assign bus.busy        = (state == RX_RECEIVING);
  assign bus.frame_error = frame_error;

  rx_word_buffer #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (done),
    .word        (word),
    .ready       (bus.data_ready),
    .overrun_clr (bus.overrun_clr),
    .data        (bus.data_out),
    .valid       (bus.data_valid),
    .overrun     (bus.overrun)
  );

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed scoreboard bench for rx_deserializer,
// WIDTH=8 and GAP_TIMEOUT=4.
module tb_rx_deserializer;
  import serdes_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [WIDTH-1:0] sb[$];

  always #5 clk = ~clk;

  rx_deserializer_if #(.WIDTH(WIDTH)) bus ();

  rx_deserializer #(
    .WIDTH       (WIDTH),
    .GAP_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic b);
    bus.serial_valid = v;
    bus.serial_in    = b;
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) tick(1'b1, w[i]);
  endtask

  task automatic expect_word(input string tag);
    chk({tag, "_valid"}, bus.data_valid, 1);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) chk(tag, bus.data_out, sb[0]);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst              = 1'b1;
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;
    bus.data_ready   = 1'b0;
    bus.overrun_clr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ferr", bus.frame_error, 0);
    chk("rst_ovr", bus.overrun, 0);
    rst = 1'b0;

    // 0xA5, consumer always ready
    bus.data_ready = 1'b1;
    w = 8'hA5;
    sb.push_back(w);
    for (int i = 0; i < WIDTH; i++) begin
      tick(1'b1, w[i]);
      if (i == 0) chk("a5_busy", bus.busy, 1);
      if (i < WIDTH - 1) chk("a5_early", bus.data_valid, 0);
    end
    chk("a5_idle", bus.busy, 0);
    expect_word("a5");
    tick(1'b0, 1'b0);
    void'(sb.pop_front());
    chk("a5_one_cycle", bus.data_valid, 0);

    // 0x3C held, 0xC3 dropped
    bus.data_ready = 1'b0;
    sb.push_back(8'h3C);
    send(8'h3C);
    expect_word("3c");
    chk("3c_no_ovr", bus.overrun, 0);
    send(8'hC3);
    expect_word("3c_held");
    chk("c3_ovr", bus.overrun, 1);
    bus.overrun_clr = 1'b1;
    tick(1'b0, 1'b0);
    bus.overrun_clr = 1'b0;
    chk("ovr_clr", bus.overrun, 0);
    chk("ovr_clr_valid", bus.data_valid, 1);
    bus.data_ready = 1'b1;
    tick(1'b0, 1'b0);
    void'(sb.pop_front());
    chk("3c_drain", bus.data_valid, 0);

    // gap timeout abort
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int g = 0; g < 4; g++) begin
      tick(1'b0, 1'b0);
      if (g < 3) begin
        chk("gap_ferr_lo", bus.frame_error, 0);
        chk("gap_busy", bus.busy, 1);
      end
    end
    chk("gap_ferr", bus.frame_error, 1);
    chk("gap_idle", bus.busy, 0);
    chk("gap_novalid", bus.data_valid, 0);
    tick(1'b0, 1'b0);
    chk("gap_pulse", bus.frame_error, 0);
    sb.push_back(8'h0F);
    send(8'h0F);
    expect_word("0f");
    tick(1'b0, 1'b0);
    void'(sb.pop_front());

    // 0x81 with a short gap
    w = 8'h81;
    sb.push_back(w);
    for (int i = 0; i < 4; i++) tick(1'b1, w[i]);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("81_gap_ferr", bus.frame_error, 0);
    chk("81_gap_busy", bus.busy, 1);
    for (int i = 4; i < WIDTH; i++) tick(1'b1, w[i]);
    expect_word("81");
    chk("81_ferr", bus.frame_error, 0);
    tick(1'b0, 1'b0);
    void'(sb.pop_front());

    // reset mid-word
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    chk("mrst_valid", bus.data_valid, 0);
    chk("mrst_data", bus.data_out, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_ferr", bus.frame_error, 0);
    chk("mrst_ovr", bus.overrun, 0);
    rst = 1'b0;
    sb.push_back(8'h5A);
    send(8'h5A);
    expect_word("5a");
    tick(1'b0, 1'b0);
    void'(sb.pop_front());

    // completion coincides with transfer
    bus.data_ready = 1'b0;
    sb.push_back(8'h11);
    send(8'h11);
    expect_word("11");
    w = 8'h22;
    sb.push_back(w);
    for (int i = 0; i < WIDTH - 1; i++) tick(1'b1, w[i]);
    bus.data_ready = 1'b1;
    tick(1'b1, w[WIDTH-1]);
    void'(sb.pop_front());
    expect_word("22");
    chk("22_ovr", bus.overrun, 0);
    tick(1'b0, 1'b0);
    void'(sb.pop_front());
    chk("22_drain", bus.data_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_deserializer.md
RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits (>= 2).
REQ-002 Parameter GAP_TIMEOUT, default 4, consecutive idle cycles mid-word before the partial word is aborted (>= 1).
REQ-003 Port clk  input  1  single clock, all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port serial_in  input  1  serial data bit, LSB of word first.
REQ-006 Port serial_valid  input  1  serial_in carries a valid bit this cycle.
REQ-007 Port data_out  output  WIDTH  assembled parallel word, held stable while data_valid=1.
REQ-008 Port data_valid  output  1  data_out holds an unconsumed word.
REQ-009 Port data_ready  input  1  consumer accepts data_out this cycle when data_valid=1.
REQ-010 Port busy  output  1  a word is partially received (state RX_RECEIVING).
REQ-011 Port frame_error  output  1  one-cycle pulse: partial word aborted by gap timeout.
REQ-012 Port overrun  output  1  sticky: a completed word was dropped because the buffer was full.
REQ-013 Port overrun_clr  input  1  clears overrun; the set condition wins if both occur in the same cycle.

Function
REQ-014 FSM states RX_IDLE and RX_RECEIVING; reset state RX_IDLE.
REQ-015 RX_IDLE, serial_valid=1: sample serial_in into shift bit 0, bit counter=1, go to RX_RECEIVING.
REQ-016 RX_RECEIVING, serial_valid=1: sample serial_in into bit index = counter, counter+1, gap counter cleared.
REQ-017 Bit sampled at index WIDTH-1: word complete, counter=0, return to RX_IDLE in the same edge.
REQ-018 RX_RECEIVING, serial_valid=0: hold counter and partial word, gap counter+1.
REQ-019 Gap counter reaches GAP_TIMEOUT: discard the partial word, frame_error=1 for exactly one cycle, go to RX_IDLE.
REQ-020 Counter width = $clog2(WIDTH); gap counter width = $clog2(GAP_TIMEOUT+1); neither wraps.
REQ-021 Completion with data_valid=0: data_out loaded and data_valid=1 on the cycle after the last bit is sampled (latency 1).
REQ-022 Handshake: transfer occurs when data_valid=1 and data_ready=1; data_valid falls next cycle unless a new word completes.
REQ-023 Completion in the same cycle as a transfer: the new word is loaded and data_valid stays 1; no overrun.
REQ-024 Completion with data_valid=1 and data_ready=0: the new word is dropped, the old data_out is kept, and overrun is set.
REQ-025 data_ready has no effect while data_valid=0.
REQ-026 A bit with serial_valid=1 in RX_IDLE immediately after completion starts a new word; back-to-back words need no idle cycle.

Reset
REQ-027 rst=1 at a clock edge: state RX_IDLE, counters 0, shift register 0, data_out 0, data_valid 0, busy 0, frame_error 0, overrun 0.
REQ-028 Reset mid-word or with data_valid=1 discards all held data; no frame_error and no overrun are raised.

Structure
REQ-029 Package serdes_pkg holds enum rx_state_e {RX_IDLE, RX_RECEIVING} and constant SERDES_WIDTH_DEFAULT=8, shared with the transmit side.
REQ-030 Sub-module rx_word_buffer implements the one-entry output register with valid/ready and overrun logic; FSM, shift register and counters stay in the top module.

Verification (WIDTH=8, GAP_TIMEOUT=4)
REQ-031 0xA5 sent LSB first on 8 consecutive valid cycles, data_ready=1 -> data_out=0xA5 and data_valid high exactly 1 cycle, one cycle after bit 7.
REQ-032 0x3C then 0xC3 back-to-back with data_ready=0 -> data_out stays 0x3C, overrun=1 after the second word; overrun_clr pulse -> overrun=0.
REQ-033 3 bits, then serial_valid=0 for 4 cycles -> frame_error one-cycle pulse, no data_valid; a following 0x0F is received correctly.
REQ-034 0x81 with a 2-cycle serial_valid gap after bit 3 -> data_out=0x81, no frame_error.
REQ-035 rst asserted after 5 bits of 0xFF -> all outputs 0 next cycle; a following 0x5A is received as 0x5A.
REQ-036 data_valid=1 (0x11), data_ready=1 in the cycle 0x22 completes -> 0x11 consumed, data_out=0x22, data_valid stays 1, overrun=0.
